// File: rtl/word_serial_tx_pkg.sv
// Shared types and helpers for the word serial transmitter.
// Optional parity bit controlled by macro TX_PARITY_EN.
package tx_pkg;

   localparam int DATA_BITS = 8;

`ifdef TX_PARITY_EN
   localparam int PARITY_BITS = 1;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      START,
      DATA,
      PARITY,
      STOP,
      GAP
   } tx_state_e;
`else
   localparam int PARITY_BITS = 0;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      START,
      DATA,
      STOP,
      GAP
   } tx_state_e;
`endif

   // Baud periods in one frame: start + data + optional parity + stop bits.
   function automatic int frame_periods(input int stop_bits);
      return 1 + DATA_BITS + PARITY_BITS + stop_bits;
   endfunction

   function automatic logic byte_parity(input logic [DATA_BITS-1:0] b, input logic odd);
      return (^b) ^ odd;
   endfunction

endpackage

// File: rtl/word_serial_tx_if.sv
// Word-load handshake and serial line bundle between a word source and the transmitter.
interface word_serial_tx_if #(
   parameter int NUM_BYTES = 4
);
   logic [8*NUM_BYTES-1:0] Data_In;
   logic                   Load;
   logic                   Busy;
   logic                   Serial_Out;
   logic                   Done;

   modport master (
      output Data_In,
      output Load,
      input  Busy,
      input  Serial_Out,
      input  Done
   );

   modport slave (
      input  Data_In,
      input  Load,
      output Busy,
      output Serial_Out,
      output Done
   );
endinterface

// File: rtl/word_serial_tx_baud_tick_gen.sv
// Rising-edge detector on the shared baud square wave: one-CLK tick per baud period.
module baud_tick_gen (
   input  logic CLK,
   input  logic CLR,
   input  logic CLK_Baud,
   output logic tick
);

   logic baud_q;

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         baud_q <= 1'b0;
      end else begin
         baud_q <= CLK_Baud;
      end
   end

   assign tick = CLK_Baud & ~baud_q;

endmodule

// File: rtl/word_serial_tx.sv
// Word-to-UART transmitter: one word per Load, sent as NUM_BYTES frames LSB byte first.
// Parity bit per frame present only when macro TX_PARITY_EN is defined.
module word_serial_tx
   import tx_pkg::*;
#(
   parameter int NUM_BYTES  = 4,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int GAP_BITS   = 0
) (
   input  logic           CLK,
   input  logic           CLR,
   input  logic           CLK_Baud,
   word_serial_tx_if.slave tx
);

   localparam int W    = DATA_BITS * NUM_BYTES;
   localparam int BI_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

   tx_state_e             state_q, state_d;
   logic [W-1:0]          shift_q, shift_d;
   logic [BI_W-1:0]       byte_idx_q, byte_idx_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic                  out_q, out_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  tick;
   logic [DATA_BITS-1:0]  cur_byte;
   logic                  last_byte;

   baud_tick_gen u_tick (
      .CLK      (CLK),
      .CLR      (CLR),
      .CLK_Baud (CLK_Baud),
      .tick     (tick)
   );

   // The byte in flight always sits in the low bits; it is shifted away at the end of its frame.
   assign cur_byte  = shift_q[DATA_BITS-1:0];
   assign last_byte = (byte_idx_q == BI_W'(NUM_BYTES - 1));

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      byte_idx_d = byte_idx_q;
      bit_cnt_d  = bit_cnt_q;
      out_d      = out_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         IDLE: begin
            out_d = 1'b1;
            if (tx.Load && !busy_q) begin
               shift_d    = tx.Data_In;
               byte_idx_d = '0;
               bit_cnt_d  = '0;
               busy_d     = 1'b1;
               state_d    = ARM;
            end
         end

         ARM: begin
            if (tick) begin
               out_d   = 1'b0;
               state_d = START;
            end
         end

         START: begin
            if (tick) begin
               out_d     = cur_byte[0];
               bit_cnt_d = '0;
               state_d   = DATA;
            end
         end

         DATA: begin
            if (tick) begin
               if (bit_cnt_q == 3'd7) begin
`ifdef TX_PARITY_EN
                  out_d   = byte_parity(cur_byte, PARITY_ODD != 0);
                  state_d = PARITY;
`else
                  out_d     = 1'b1;
                  bit_cnt_d = '0;
                  state_d   = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  out_d     = cur_byte[bit_cnt_q + 3'd1];
               end
            end
         end

`ifdef TX_PARITY_EN
         PARITY: begin
            if (tick) begin
               out_d     = 1'b1;
               bit_cnt_d = '0;
               state_d   = STOP;
            end
         end
`endif

         STOP: begin
            if (tick) begin
               if (bit_cnt_q == 3'(STOP_BITS - 1)) begin
                  bit_cnt_d = '0;
                  if (last_byte) begin
                     out_d   = 1'b1;
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     state_d = IDLE;
                  end else begin
                     byte_idx_d = byte_idx_q + 1'b1;
                     shift_d    = shift_q >> DATA_BITS;
                     if (GAP_BITS > 0) begin
                        out_d   = 1'b1;
                        state_d = GAP;
                     end else begin
                        out_d   = 1'b0;
                        state_d = START;
                     end
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end

         GAP: begin
            if (tick) begin
               if (bit_cnt_q == 3'(GAP_BITS - 1)) begin
                  bit_cnt_d = '0;
                  out_d     = 1'b0;
                  state_d   = START;
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end

         default: begin
            out_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         byte_idx_q <= '0;
         bit_cnt_q  <= '0;
         out_q      <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         byte_idx_q <= byte_idx_d;
         bit_cnt_q  <= bit_cnt_d;
         out_q      <= out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign tx.Serial_Out = out_q;
   assign tx.Busy       = busy_q;
   assign tx.Done       = done_q;

endmodule

// File: tb/tb_word_serial_tx.sv
// Bench for word_serial_tx: a bench-side UART receiver decodes the line of a default
// instance and a swept instance (odd parity, 2 stop bits, 3 gap periods).
module tb_word_serial_tx;

   localparam int BAUD = 4;
`ifdef TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif
   localparam int FR0    = (1 + 8 + P + 1) * BAUD;
   localparam int FR1    = (1 + 8 + P + 2 + 3) * BAUD;
   localparam int TICKS0 = 4 * (10 + P) + 1;
   localparam int TICKS1 = 4 * (11 + P) + 3 * 3 + 1;

   logic CLK = 1'b0;
   logic CLR = 1'b1;
   logic CLK_Baud = 1'b0;
   logic baud_prev = 1'b0;
   int   tick_cnt = 0;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;

   always #5 CLK = ~CLK;
   always #20 CLK_Baud = ~CLK_Baud;

   always @(posedge CLK) begin
      baud_prev <= CLK_Baud;
      if (CLK_Baud && !baud_prev) tick_cnt <= tick_cnt + 1;
      cyc <= cyc + 1;
   end

   word_serial_tx_if #(.NUM_BYTES(4)) bus0 ();
   word_serial_tx_if #(.NUM_BYTES(4)) bus1 ();

   word_serial_tx #(.NUM_BYTES(4), .PARITY_ODD(0), .STOP_BITS(1), .GAP_BITS(0)) dut0 (
      .CLK(CLK), .CLR(CLR), .CLK_Baud(CLK_Baud), .tx(bus0)
   );
   word_serial_tx #(.NUM_BYTES(4), .PARITY_ODD(1), .STOP_BITS(2), .GAP_BITS(3)) dut1 (
      .CLK(CLK), .CLR(CLR), .CLK_Baud(CLK_Baud), .tx(bus1)
   );

   typedef struct {
      int              d;
      logic [31:0]     data;
      logic [0:3][7:0] seq;
      logic [3:0]      par;
   } vec_t;

   vec_t tbl [5];

   function automatic logic line(input int d);
      return (d == 1) ? bus1.Serial_Out : bus0.Serial_Out;
   endfunction
   function automatic logic busy(input int d);
      return (d == 1) ? bus1.Busy : bus0.Busy;
   endfunction
   function automatic logic done(input int d);
      return (d == 1) ? bus1.Done : bus0.Done;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic drive(input int d, input logic ld, input logic [31:0] w);
      if (d == 1) begin bus1.Load = ld; bus1.Data_In = w; end
      else begin bus0.Load = ld; bus0.Data_In = w; end
   endtask

   task automatic start_word(input int d, input logic [31:0] w, output int t_acc);
      @(negedge CLK);
      drive(d, 1'b1, w);
      @(negedge CLK);
      drive(d, 1'b0, w);
      chk("busy_after_load", busy(d), 1'b1);
      t_acc = tick_cnt;
   endtask

   task automatic recv_word(input int d, input logic [0:3][7:0] seq, input logic [3:0] par,
                            input int stops, input int frame_cyc, input string tag,
                            output logic [31:0] got);
      int t_prev = 0;
      logic [7:0] b;
      got = '0;
      for (int f = 0; f < 4; f++) begin
         int n = 0;
         while (line(d) !== 1'b0 && n < 600) begin
            @(negedge CLK);
            n++;
         end
         if (n >= 600) begin
            chk({tag, "_start_timeout"}, line(d), 1'b0);
            return;
         end
         if (f > 0) chk({tag, "_frame_spacing"}, cyc - t_prev, frame_cyc);
         t_prev = cyc;
         repeat (2) @(negedge CLK);
         chk({tag, "_start_bit"}, line(d), 1'b0);
         for (int i = 0; i < 8; i++) begin
            repeat (BAUD) @(negedge CLK);
            b[i] = line(d);
         end
         chk({tag, "_byte"}, b, seq[f]);
         got[8*f +: 8] = b;
`ifdef TX_PARITY_EN
         repeat (BAUD) @(negedge CLK);
         chk({tag, "_parity"}, line(d), par[f]);
`endif
         for (int s = 0; s < stops; s++) begin
            repeat (BAUD) @(negedge CLK);
            chk({tag, "_stop_bit"}, line(d), 1'b1);
         end
      end
   endtask

   task automatic wait_done(input int d, input int t_acc, input int exp_ticks,
                            input string tag, input logic exp_busy_after);
      int n = 0;
      while (done(d) !== 1'b1 && n < 200) begin
         @(negedge CLK);
         n++;
      end
      if (n >= 200) begin
         chk({tag, "_done_timeout"}, done(d), 1'b1);
         return;
      end
      chk({tag, "_done_ticks"}, tick_cnt - t_acc, exp_ticks);
      chk({tag, "_busy_in_done"}, busy(d), 1'b0);
      @(negedge CLK);
      chk({tag, "_done_width"}, done(d), 1'b0);
      chk({tag, "_busy_after_done"}, busy(d), exp_busy_after);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t_acc;
      int n;
      logic [31:0] got;
      logic seen_low;

      drive(0, 1'b0, 32'h0);
      drive(1, 1'b0, 32'h0);

      tbl[0] = '{0, 32'h12345607, {8'h07, 8'h56, 8'h34, 8'h12}, 4'b0101};
      tbl[1] = '{0, 32'hA5C30180, {8'h80, 8'h01, 8'hC3, 8'hA5}, 4'b0011};
      tbl[2] = '{0, 32'h7F3E5D02, {8'h02, 8'h5D, 8'h3E, 8'h7F}, 4'b1111};
      tbl[3] = '{0, 32'h00000000, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000};
      tbl[4] = '{1, 32'h000000FF, {8'hFF, 8'h00, 8'h00, 8'h00}, 4'b1111};

      // Reset and idle line
      repeat (3) @(negedge CLK);
      chk("reset_dut0", {line(0), busy(0), done(0)}, 3'b100);
      chk("reset_dut1", {line(1), busy(1), done(1)}, 3'b100);
      CLR = 1'b0;
      for (int i = 0; i < 20 * BAUD; i++) begin
         @(negedge CLK);
         chk("idle_dut0", {line(0), busy(0), done(0)}, 3'b100);
         chk("idle_dut1", {line(1), busy(1), done(1)}, 3'b100);
      end

      // Table-driven words
      for (int i = 0; i < 5; i++) begin
         start_word(tbl[i].d, tbl[i].data, t_acc);
         recv_word(tbl[i].d, tbl[i].seq, tbl[i].par, (tbl[i].d == 1) ? 2 : 1,
                   (tbl[i].d == 1) ? FR1 : FR0, "tbl", got);
         wait_done(tbl[i].d, t_acc, (tbl[i].d == 1) ? TICKS1 : TICKS0, "tbl", 1'b0);
         repeat (7) @(negedge CLK);
      end

      // Load held high while busy with new data, accepted only after the Done cycle
      start_word(0, 32'h12345607, t_acc);
      drive(0, 1'b1, 32'hFFFFFFFF);
      recv_word(0, tbl[0].seq, tbl[0].par, 1, FR0, "busy_ign", got);
      wait_done(0, t_acc, TICKS0, "busy_ign", 1'b1);
      drive(0, 1'b0, 32'hFFFFFFFF);
      t_acc = tick_cnt;
      recv_word(0, {8'hFF, 8'hFF, 8'hFF, 8'hFF}, 4'b0000, 1, FR0, "b2b", got);
      wait_done(0, t_acc, TICKS0, "b2b", 1'b0);
      seen_low = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge CLK);
         if (line(0) !== 1'b1 || busy(0) !== 1'b0) seen_low = 1'b1;
      end
      chk("no_extra_frames", seen_low, 1'b0);

      // Asynchronous reset during data bit 1 of byte 2 (0x34, bit 1 = 0)
      start_word(0, 32'h12345607, t_acc);
      n = 0;
      while ((tick_cnt - t_acc) < (2 * (10 + P) + 3) && n < 600) begin
         @(negedge CLK);
         n++;
      end
      chk("pre_reset_line", line(0), 1'b0);
      chk("pre_reset_busy", busy(0), 1'b1);
      #2 CLR = 1'b1;
      #1;
      chk("async_reset_line", line(0), 1'b1);
      chk("async_reset_busy", busy(0), 1'b0);
      @(negedge CLK);
      CLR = 1'b0;
      repeat (5) @(negedge CLK);
      start_word(0, tbl[1].data, t_acc);
      recv_word(0, tbl[1].seq, tbl[1].par, 1, FR0, "post_reset", got);
      wait_done(0, t_acc, TICKS0, "post_reset", 1'b0);

      // Random words with varied load phase against the baud wave
      for (int k = 0; k < 100; k++) begin
         logic [31:0] w;
         logic [0:3][7:0] seq;
         logic [3:0] par;
         w = $urandom;
         for (int f = 0; f < 4; f++) begin
            seq[f] = w[8*f +: 8];
            par[f] = ^w[8*f +: 8];
         end
         repeat ($urandom_range(0, 5)) @(negedge CLK);
         start_word(0, w, t_acc);
         recv_word(0, seq, par, 1, FR0, "rand", got);
         chk("rand_word", got, w);
         wait_done(0, t_acc, TICKS0, "rand", 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
